axi_tdd_ng_sync_ctrl: RTL and testbench
=======================================

Name: axi_tdd_ng_sync_ctrl

Overview:
Sequencer in front of the TDD frame counter. It generates the single-cycle tdd_sync pulse from three sources: a periodic internal timer, an external sync pin and a software request. It also holds shadow copies of the counter configuration (burst count, startup delay, frame length). Shadow values change only while the counter is IDLE or ARMED, so a running burst never sees a mid-frame reconfiguration.

Parameters:
REGISTER_WIDTH, 32, width of startup delay and frame length.
BURST_COUNT_WIDTH, 32, width of burst count.
SYNC_COUNT_WIDTH, 64, width of the internal sync period timer.

Ports:
clk  in  1  clock
resetn  in  1  reset resetn, synchronous, active-low; clock clk
tdd_enable  in  1  global enable; 0 clears the timer and forces immediate config load
tdd_cstate  in  axi_tdd_ng_pkg::state_t  current counter state
sync_int_en  in  1  enable internal periodic sync
sync_ext_en  in  1  enable external sync source
sync_soft  in  1  software sync request, single-cycle pulse
sync_ext  in  1  raw external sync pin, level, asynchronous when CDC enabled
sync_period  in  SYNC_COUNT_WIDTH  internal sync period in clk cycles; 0 = internal source disabled
cfg_update  in  1  single-cycle pulse: latch cfg_* into the pending set
cfg_burst_count  in  BURST_COUNT_WIDTH  requested burst count
cfg_startup_delay  in  REGISTER_WIDTH  requested startup delay
cfg_frame_length  in  REGISTER_WIDTH  requested frame length
tdd_sync  out  1  registered sync pulse to the counter
tdd_burst_count  out  BURST_COUNT_WIDTH  shadowed burst count
tdd_startup_delay  out  REGISTER_WIDTH  shadowed startup delay
tdd_frame_length  out  REGISTER_WIDTH  shadowed frame length
cfg_pending  out  1  1 while a captured config is waiting to be applied

Behaviour:
- Reset: all outputs 0; timer 0; synchronizer and edge registers 0; config FSM in CFG_IDLE.
- Internal timer:
  - Counts while tdd_enable & sync_int_en & (sync_period != 0); otherwise held at 0.
  - When timer == sync_period-1: timer wraps to 0 and internal request = 1 for that cycle.
  - sync_period = 1 gives a request every cycle.
  - A sync_period change mid-count takes effect on the next compare. If the new period is already below the timer value, the timer runs to 2^SYNC_COUNT_WIDTH and wraps; this is accepted behaviour.
- External source:
  - Rising edge of the synchronized sync_ext, gated by sync_ext_en. Held high = one request only.
- Software source: sync_soft is gated by tdd_enable only.
- tdd_sync:
  - Registered OR of the three requests, gated by tdd_enable; 1-cycle latency from the request cycle.
  - Simultaneous requests produce one pulse.
  - Back-to-back requests produce back-to-back pulses; there is no merging across cycles.
- Config FSM states:
  - CFG_IDLE: cfg_update captures cfg_* into pending registers, sets cfg_pending, goes to CFG_WAIT.
  - CFG_WAIT: loads the shadow outputs from the pending registers, clears cfg_pending and returns to CFG_IDLE when any of these holds:
    - tdd_enable == 0;
    - tdd_cstate == IDLE;
    - tdd_cstate == ARMED and tdd_sync == 0 in that cycle.
  - While RUNNING or WAITING, the FSM stays in CFG_WAIT.
  - cfg_update during CFG_WAIT overwrites the pending registers (last write wins) and stays in CFG_WAIT.
  - cfg_update in the same cycle as a load: the new values go to pending, cfg_pending stays 1, and the FSM remains in CFG_WAIT.
- Shadow outputs change only on a load cycle and are visible the following cycle.
- tdd_enable falling mid-burst: timer cleared at once, tdd_sync forced 0 from the next cycle, pending config applied.

Optional Feature:
AXI_TDD_NG_SYNC_EXT_CDC_EN
- Defined: sync_ext passes through a 2-FF synchronizer before the edge register. Rising edge on the pin to tdd_sync high = 4 clk edges (2 synchronizer + 1 edge detect + 1 output register).
- Undefined: sync_ext is treated as synchronous to clk; only the edge register is used, giving 2 clk edges of latency.

Decomposition:
- axi_tdd_ng_pkg gains:
  - enum sync_cfg_state_t {CFG_IDLE, CFG_WAIT};
  - localparam SYNC_EXT_CDC_STAGES = 2.
- Existing state_t is reused.
- Sub-module axi_tdd_ng_sync_edge: optional synchronizer plus rising-edge detector with enable. It is instanced once for sync_ext.

Test Plan:
1. sync_int_en=1, sync_period=5, tdd_enable=1 -> tdd_sync pulses at cycles 5, 10, 15 after enable; sync_period=0 -> no pulses.
2. sync_ext held high 20 cycles with CDC_EN defined -> exactly one tdd_sync, 4 cycles after the rise; sync_ext_en=0 -> none.
3. sync_soft and internal request in the same cycle -> single one-cycle tdd_sync; consecutive-cycle requests -> two adjacent pulses.
4. tdd_cstate=RUNNING, cfg_update with frame_length=100 -> outputs unchanged, cfg_pending=1. tdd_cstate->ARMED with no sync -> tdd_frame_length=100 one cycle later, cfg_pending=0.
5. Two cfg_update pulses (frame_length 50 then 70) while RUNNING, then IDLE -> tdd_frame_length=70 only.
6. resetn=0 mid-count with cfg pending -> next cycle all outputs 0, cfg_pending=0, no tdd_sync until a new request.

Source files
------------

// File: rtl/axi_tdd_ng_pkg.sv
// -----------------------------------------------------------------------------
// axi_tdd_ng_pkg
// Shared types and constants for the TDD frame-counter block.
//   state_t          : frame counter state, as seen by the sync sequencer
//   sync_cfg_state_t : shadow-config loader state
//   SYNC_EXT_CDC_STAGES : depth of the external sync synchronizer
// -----------------------------------------------------------------------------
package axi_tdd_ng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2,
        WAITING = 2'd3
    } state_t;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_WAIT = 1'b1
    } sync_cfg_state_t;

    localparam int SYNC_EXT_CDC_STAGES = 2;

endpackage

// File: rtl/axi_tdd_ng_sync_edge.sv
// -----------------------------------------------------------------------------
// axi_tdd_ng_sync_edge
// Optional synchronizer followed by a registered rising-edge detector.
// Build option: AXI_TDD_NG_SYNC_EXT_CDC_EN adds a SYNC_EXT_CDC_STAGES-deep
// synchronizer in front of the edge register (pin treated as asynchronous).
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   din         : raw input level
//   en          : gates the edge output
//   rise        : one-cycle pulse on a rising edge of din (when en)
// -----------------------------------------------------------------------------
module axi_tdd_ng_sync_edge
    import axi_tdd_ng_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic din,
    input  logic en,
    output logic rise
);

    logic din_s;

`ifdef AXI_TDD_NG_SYNC_EXT_CDC_EN
    logic [SYNC_EXT_CDC_STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[SYNC_EXT_CDC_STAGES-2:0], din};

    always_ff @(posedge clk) begin
        if (!resetn) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign din_s = sync_q[SYNC_EXT_CDC_STAGES-1];
`else
    assign din_s = din;
`endif

    // edge_q[0] registers the level, edge_q[1] is its previous value; the
    // detect is taken between the two so the pin always sees one register
    // before the compare.
    logic [1:0] edge_q, edge_d;

    always_comb edge_d = {edge_q[0], din_s};

    always_ff @(posedge clk) begin
        if (!resetn) edge_q <= '0;
        else         edge_q <= edge_d;
    end

    assign rise = en & edge_q[0] & ~edge_q[1];

endmodule

// File: rtl/axi_tdd_ng_sync_ctrl.sv
// -----------------------------------------------------------------------------
// axi_tdd_ng_sync_ctrl
// Generates the single-cycle tdd_sync pulse from an internal periodic timer,
// an external sync pin and a software request, and holds shadow copies of
// the counter configuration that only update while the counter is IDLE,
// ARMED (without a sync in that cycle) or disabled.
// Build option: AXI_TDD_NG_SYNC_EXT_CDC_EN (2-FF synchronizer on sync_ext).
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   tdd_enable         : global enable
//   tdd_cstate         : current frame counter state
//   sync_int_en/ext_en : source enables; sync_soft: software pulse
//   sync_ext           : external sync pin; sync_period: internal period
//   cfg_update, cfg_*  : config capture pulse and requested values
//   tdd_sync           : registered sync pulse
//   tdd_*              : shadowed config; cfg_pending: capture awaiting load
// -----------------------------------------------------------------------------
module axi_tdd_ng_sync_ctrl
    import axi_tdd_ng_pkg::*;
#(
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32,
    parameter int SYNC_COUNT_WIDTH  = 64
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         tdd_enable,
    input  state_t                       tdd_cstate,
    input  logic                         sync_int_en,
    input  logic                         sync_ext_en,
    input  logic                         sync_soft,
    input  logic                         sync_ext,
    input  logic [SYNC_COUNT_WIDTH-1:0]  sync_period,
    input  logic                         cfg_update,
    input  logic [BURST_COUNT_WIDTH-1:0] cfg_burst_count,
    input  logic [REGISTER_WIDTH-1:0]    cfg_startup_delay,
    input  logic [REGISTER_WIDTH-1:0]    cfg_frame_length,
    output logic                         tdd_sync,
    output logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
    output logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
    output logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
    output logic                         cfg_pending
);

    // ---------------- sync sources ----------------
    logic [SYNC_COUNT_WIDTH-1:0] timer_q, timer_d;
    logic                        int_req, ext_req;
    logic                        tdd_sync_q, tdd_sync_d;

    always_comb begin
        timer_d = '0;
        int_req = 1'b0;
        if (tdd_enable && sync_int_en && (sync_period != '0)) begin
            // Exact compare: a period shrunk below the current count lets the
            // timer run through the full range before wrapping.
            if (timer_q == sync_period - SYNC_COUNT_WIDTH'(1)) begin
                int_req = 1'b1;
            end else begin
                timer_d = timer_q + SYNC_COUNT_WIDTH'(1);
            end
        end
    end

    axi_tdd_ng_sync_edge u_sync_ext_edge (
        .clk    (clk),
        .resetn (resetn),
        .din    (sync_ext),
        .en     (sync_ext_en),
        .rise   (ext_req)
    );

    always_comb tdd_sync_d = tdd_enable & (int_req | ext_req | sync_soft);

    // ---------------- shadow config ----------------
    sync_cfg_state_t              state_q, state_d;
    logic [BURST_COUNT_WIDTH-1:0] pend_burst_q, pend_burst_d;
    logic [REGISTER_WIDTH-1:0]    pend_delay_q, pend_delay_d;
    logic [REGISTER_WIDTH-1:0]    pend_frame_q, pend_frame_d;
    logic [BURST_COUNT_WIDTH-1:0] burst_q, burst_d;
    logic [REGISTER_WIDTH-1:0]    delay_q, delay_d;
    logic [REGISTER_WIDTH-1:0]    frame_q, frame_d;
    logic                         load_ok;

    // tdd_sync_q is the pulse the counter sees this cycle; an ARMED counter
    // receiving it is starting a burst, so the load must hold off.
    assign load_ok = !tdd_enable || (tdd_cstate == IDLE) ||
                     ((tdd_cstate == ARMED) && !tdd_sync_q);

    always_comb begin
        state_d      = state_q;
        pend_burst_d = pend_burst_q;
        pend_delay_d = pend_delay_q;
        pend_frame_d = pend_frame_q;
        burst_d      = burst_q;
        delay_d      = delay_q;
        frame_d      = frame_q;
        case (state_q)
            CFG_IDLE: begin
                if (cfg_update) state_d = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (load_ok) begin
                    burst_d = pend_burst_q;
                    delay_d = pend_delay_q;
                    frame_d = pend_frame_q;
                    // A capture landing on the load cycle keeps us waiting.
                    if (!cfg_update) state_d = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
        if (cfg_update) begin
            pend_burst_d = cfg_burst_count;
            pend_delay_d = cfg_startup_delay;
            pend_frame_d = cfg_frame_length;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer_q      <= '0;
            tdd_sync_q   <= 1'b0;
            state_q      <= CFG_IDLE;
            pend_burst_q <= '0;
            pend_delay_q <= '0;
            pend_frame_q <= '0;
            burst_q      <= '0;
            delay_q      <= '0;
            frame_q      <= '0;
        end else begin
            timer_q      <= timer_d;
            tdd_sync_q   <= tdd_sync_d;
            state_q      <= state_d;
            pend_burst_q <= pend_burst_d;
            pend_delay_q <= pend_delay_d;
            pend_frame_q <= pend_frame_d;
            burst_q      <= burst_d;
            delay_q      <= delay_d;
            frame_q      <= frame_d;
        end
    end

    assign tdd_sync          = tdd_sync_q;
    assign tdd_burst_count   = burst_q;
    assign tdd_startup_delay = delay_q;
    assign tdd_frame_length  = frame_q;
    assign cfg_pending       = (state_q == CFG_WAIT);

endmodule

// File: tb/tb_axi_tdd_ng_sync_ctrl.sv
module tb_axi_tdd_ng_sync_ctrl;
    import axi_tdd_ng_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tdd_enable;
    state_t      tdd_cstate;
    logic        sync_int_en, sync_ext_en, sync_soft, sync_ext;
    logic [63:0] sync_period;
    logic        cfg_update;
    logic [31:0] cfg_burst_count, cfg_startup_delay, cfg_frame_length;
    logic        tdd_sync;
    logic [31:0] tdd_burst_count, tdd_startup_delay, tdd_frame_length;
    logic        cfg_pending;

    int n_chk = 0;
    int n_err = 0;

`ifdef AXI_TDD_NG_SYNC_EXT_CDC_EN
    localparam int EXT_LAT = 4;
`else
    localparam int EXT_LAT = 2;
`endif

    always #5 clk = ~clk;

    axi_tdd_ng_sync_ctrl dut (
        .clk               (clk),
        .resetn            (resetn),
        .tdd_enable        (tdd_enable),
        .tdd_cstate        (tdd_cstate),
        .sync_int_en       (sync_int_en),
        .sync_ext_en       (sync_ext_en),
        .sync_soft         (sync_soft),
        .sync_ext          (sync_ext),
        .sync_period       (sync_period),
        .cfg_update        (cfg_update),
        .cfg_burst_count   (cfg_burst_count),
        .cfg_startup_delay (cfg_startup_delay),
        .cfg_frame_length  (cfg_frame_length),
        .tdd_sync          (tdd_sync),
        .tdd_burst_count   (tdd_burst_count),
        .tdd_startup_delay (tdd_startup_delay),
        .tdd_frame_length  (tdd_frame_length),
        .cfg_pending       (cfg_pending)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; sample/drive 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Run n cycles, count tdd_sync pulses and note the first one (0 = none).
    task automatic count_pulses(input int n, output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int k = 1; k <= n; k++) begin
            tick(1);
            if (tdd_sync) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
    endtask

    task automatic cfg_pulse(input logic [31:0] frame);
        cfg_update       = 1'b1;
        cfg_frame_length = frame;
        tick(1);
        cfg_update       = 1'b0;
    endtask

    int cnt, first;

    initial begin
        resetn = 1'b0; tdd_enable = 1'b0; tdd_cstate = IDLE;
        sync_int_en = 1'b0; sync_ext_en = 1'b0; sync_soft = 1'b0; sync_ext = 1'b0;
        sync_period = '0; cfg_update = 1'b0;
        cfg_burst_count = '0; cfg_startup_delay = '0; cfg_frame_length = '0;
        tick(3);
        chk("rst_sync",    64'(tdd_sync), 64'd0);
        chk("rst_frame",   64'(tdd_frame_length), 64'd0);
        chk("rst_burst",   64'(tdd_burst_count), 64'd0);
        chk("rst_pending", 64'(cfg_pending), 64'd0);
        resetn = 1'b1;
        tick(1);

        // 1. internal timer, period 5: pulses 5, 10, 15 edges after enable
        sync_period = 64'd5; sync_int_en = 1'b1; tdd_enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk($sformatf("int_p5_c%0d", k), 64'(tdd_sync), (k % 5 == 0) ? 64'd1 : 64'd0);
        end
        sync_period = '0;
        count_pulses(12, cnt, first);
        chk("int_p0_cnt", 64'(cnt), 64'd0);
        sync_int_en = 1'b0;

        // 2. external pin held high: exactly one pulse, EXT_LAT edges later
        sync_ext_en = 1'b1; sync_ext = 1'b1;
        count_pulses(20, cnt, first);
        chk("ext_cnt", 64'(cnt), 64'd1);
        chk("ext_lat", 64'(first), 64'(EXT_LAT));
        sync_ext = 1'b0; tick(5);
        sync_ext_en = 1'b0; sync_ext = 1'b1;
        count_pulses(10, cnt, first);
        chk("ext_dis_cnt", 64'(cnt), 64'd0);
        sync_ext = 1'b0; tick(5);

        // 3. soft + internal in the same cycle -> one pulse
        sync_period = 64'd3; sync_int_en = 1'b1;
        tick(1); chk("coin_c1", 64'(tdd_sync), 64'd0);
        tick(1); chk("coin_c2", 64'(tdd_sync), 64'd0);
        sync_soft = 1'b1;              // timer==2 in this cycle too
        tick(1); chk("coin_c3", 64'(tdd_sync), 64'd1);
        sync_soft = 1'b0;
        tick(1); chk("coin_c4", 64'(tdd_sync), 64'd0);
        sync_int_en = 1'b0;
        tick(1); chk("coin_c5", 64'(tdd_sync), 64'd0);
        // back-to-back soft requests -> adjacent pulses
        sync_soft = 1'b1;
        tick(1); chk("b2b_1", 64'(tdd_sync), 64'd1);
        tick(1); chk("b2b_2", 64'(tdd_sync), 64'd1);
        sync_soft = 1'b0;
        tick(1); chk("b2b_3", 64'(tdd_sync), 64'd0);
        // soft gated by tdd_enable
        tdd_enable = 1'b0; sync_soft = 1'b1;
        tick(1); chk("soft_dis", 64'(tdd_sync), 64'd0);
        sync_soft = 1'b0; tdd_enable = 1'b1;
        tick(1);

        // 4. capture while RUNNING, load on ARMED without sync
        tdd_cstate = RUNNING;
        cfg_burst_count = 32'd7; cfg_startup_delay = 32'd9;
        cfg_pulse(32'd100);
        chk("run_pend",  64'(cfg_pending), 64'd1);
        chk("run_frame", 64'(tdd_frame_length), 64'd0);
        tick(1);
        chk("run_hold",  64'(tdd_frame_length), 64'd0);
        tdd_cstate = ARMED;
        tick(1);
        chk("arm_frame", 64'(tdd_frame_length), 64'd100);
        chk("arm_burst", 64'(tdd_burst_count), 64'd7);
        chk("arm_delay", 64'(tdd_startup_delay), 64'd9);
        chk("arm_pend",  64'(cfg_pending), 64'd0);
        // ARMED with tdd_sync high in that cycle must not load
        tdd_cstate = RUNNING;
        cfg_pulse(32'd120);
        sync_soft = 1'b1;
        tick(1);
        sync_soft = 1'b0; tdd_cstate = ARMED;
        chk("armsync_pulse", 64'(tdd_sync), 64'd1);
        tick(1);
        chk("armsync_frame", 64'(tdd_frame_length), 64'd100);
        chk("armsync_pend",  64'(cfg_pending), 64'd1);
        tick(1);
        chk("armsync_load",  64'(tdd_frame_length), 64'd120);
        chk("armsync_pend0", 64'(cfg_pending), 64'd0);

        // 5. last write wins
        tdd_cstate = RUNNING;
        cfg_pulse(32'd50);
        cfg_pulse(32'd70);
        chk("lww_hold", 64'(tdd_frame_length), 64'd120);
        chk("lww_pend", 64'(cfg_pending), 64'd1);
        tdd_cstate = IDLE;
        tick(1);
        chk("lww_frame", 64'(tdd_frame_length), 64'd70);
        chk("lww_pend0", 64'(cfg_pending), 64'd0);
        // capture on a load cycle: old pending loads, new one waits
        tdd_cstate = RUNNING;
        cfg_pulse(32'd30);
        tdd_cstate = IDLE;
        cfg_pulse(32'd40);
        chk("ovl_frame", 64'(tdd_frame_length), 64'd30);
        chk("ovl_pend",  64'(cfg_pending), 64'd1);
        tick(1);
        chk("ovl_frame2", 64'(tdd_frame_length), 64'd40);
        chk("ovl_pend0",  64'(cfg_pending), 64'd0);
        // tdd_enable low forces load
        tdd_cstate = RUNNING;
        cfg_pulse(32'd55);
        tdd_enable = 1'b0;
        tick(1);
        chk("dis_frame", 64'(tdd_frame_length), 64'd55);
        chk("dis_pend",  64'(cfg_pending), 64'd0);
        tdd_enable = 1'b1;

        // 6. reset mid-count with a pending config
        sync_period = 64'd5; sync_int_en = 1'b1;
        cfg_pulse(32'd77);
        tick(1);
        resetn = 1'b0;
        tick(1);
        chk("mrst_sync",  64'(tdd_sync), 64'd0);
        chk("mrst_frame", 64'(tdd_frame_length), 64'd0);
        chk("mrst_burst", 64'(tdd_burst_count), 64'd0);
        chk("mrst_delay", 64'(tdd_startup_delay), 64'd0);
        chk("mrst_pend",  64'(cfg_pending), 64'd0);
        sync_int_en = 1'b0; resetn = 1'b1;
        count_pulses(6, cnt, first);
        chk("mrst_nosync", 64'(cnt), 64'd0);
        chk("mrst_frame2", 64'(tdd_frame_length), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
